// File: rtl/cdb_arbiter_pkg.sv
// rtl/cdb_arbiter_pkg.sv - shared CDB definitions: tag width, zero register, broadcast packet
package cdb_arbiter_pkg;

   localparam int ROB_TAG_LEN = 5;
   localparam logic [4:0] ZERO_REG = 5'd0;

   typedef struct packed {
      logic                   valid;
      logic [4:0]             rd;
      logic [ROB_TAG_LEN-1:0] rob_tag;
      logic [31:0]            value;
   } cdb_packet_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin grant: first request at or after ptr wins
module rr_arbiter #(
   parameter int NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]         req,
   input  logic [$clog2(NUM_REQ)-1:0] ptr,
   output logic [NUM_REQ-1:0]         gnt
);

   localparam int PW = $clog2(NUM_REQ);

   logic          found;
   logic [PW-1:0] idx;

   always_comb begin
      gnt   = '0;
      found = 1'b0;
      idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = PW'((int'(ptr) + k) % NUM_REQ);
         if (!found && req[idx]) begin
            gnt[idx] = 1'b1;
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin arbitration of FU completions onto the registered common data bus
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 4
) (
   input  logic                                clock,
   input  logic                                reset,
   input  logic                                squash,
   input  logic [NUM_REQ-1:0]                  req_valid,
   input  logic [NUM_REQ-1:0][4:0]             req_rd,
   input  logic [NUM_REQ-1:0][ROB_TAG_LEN-1:0] req_rob_tag,
   input  logic [NUM_REQ-1:0][31:0]            req_value,
   output logic [NUM_REQ-1:0]                  req_ready,
   output logic                                cdb_valid,
   output logic [4:0]                          cdb_rd,
   output logic [ROB_TAG_LEN-1:0]              cdb_rob_tag,
   output logic [31:0]                         cdb_value
);

   localparam int PW = $clog2(NUM_REQ);

   logic [PW-1:0]      ptr_q, ptr_d;
   cdb_packet_t        cdb_q, cdb_d;
   logic [NUM_REQ-1:0] gnt;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
      .req (req_valid),
      .ptr (ptr_q),
      .gnt (gnt)
   );

   // Gating is on inputs only, so cdb_* never feed back into req_ready.
   assign req_ready = (reset || squash) ? '0 : gnt;

   always_comb begin
      ptr_d       = ptr_q;
      cdb_d       = cdb_q;
      cdb_d.valid = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (req_ready[i]) begin
            cdb_d = '{valid: 1'b1, rd: req_rd[i], rob_tag: req_rob_tag[i], value: req_value[i]};
            ptr_d = PW'((i + 1) % NUM_REQ);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         ptr_q <= '0;
         cdb_q <= '0;
      end else begin
         ptr_q <= ptr_d;
         cdb_q <= cdb_d;
      end
   end

   assign cdb_valid   = cdb_q.valid;
   assign cdb_rd      = cdb_q.rd;
   assign cdb_rob_tag = cdb_q.rob_tag;
   assign cdb_value   = cdb_q.value;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - directed and randomized checks of cdb_arbiter against a behavioural model
module tb_cdb_arbiter;
   import cdb_arbiter_pkg::*;

   localparam int N = 4;

   logic                          clock = 1'b0;
   logic                          reset = 1'b1;
   logic                          squash = 1'b0;
   logic [N-1:0]                  req_valid = '0;
   logic [N-1:0][4:0]             req_rd = '0;
   logic [N-1:0][ROB_TAG_LEN-1:0] req_rob_tag = '0;
   logic [N-1:0][31:0]            req_value = '0;
   logic [N-1:0]                  req_ready;
   logic                          cdb_valid;
   logic [4:0]                    cdb_rd;
   logic [ROB_TAG_LEN-1:0]        cdb_rob_tag;
   logic [31:0]                   cdb_value;

   cdb_arbiter #(.NUM_REQ(N)) dut (
      .clock       (clock),
      .reset       (reset),
      .squash      (squash),
      .req_valid   (req_valid),
      .req_rd      (req_rd),
      .req_rob_tag (req_rob_tag),
      .req_value   (req_value),
      .req_ready   (req_ready),
      .cdb_valid   (cdb_valid),
      .cdb_rd      (cdb_rd),
      .cdb_rob_tag (cdb_rob_tag),
      .cdb_value   (cdb_value)
   );

   always #5 clock = ~clock;

   int vectors = 0;
   int miscompares = 0;

   // Requester-side payloads and the model's view of the bus
   logic [4:0]             pl_rd [N];
   logic [ROB_TAG_LEN-1:0] pl_tag[N];
   logic [31:0]            pl_val[N];
   int                     m_ptr = 0;
   logic                   m_valid = 0;
   logic [4:0]             m_rd = 0;
   logic [ROB_TAG_LEN-1:0] m_tag = 0;
   logic [31:0]            m_val = 0;
   logic [N-1:0]           exp_gnt;
   logic [19:0]            gnt_log;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   function automatic logic [N-1:0] model_grant(input logic [N-1:0] v, input logic rst, input logic sq);
      if (rst || sq) return '0;
      for (int k = 0; k < N; k++) begin
         int i = (m_ptr + k) % N;
         if (v[i]) return N'(1 << i);
      end
      return '0;
   endfunction

   task automatic drive(input logic rst, input logic sq, input logic [N-1:0] v);
      @(negedge clock);
      reset = rst;
      squash = sq;
      req_valid = v;
      for (int i = 0; i < N; i++) begin
         req_rd[i] = pl_rd[i];
         req_rob_tag[i] = pl_tag[i];
         req_value[i] = pl_val[i];
      end
      #1;
      exp_gnt = model_grant(v, rst, sq);
      check("req_ready", 64'(req_ready), 64'(exp_gnt));
      gnt_log = {gnt_log[15:0], req_ready};
      @(posedge clock);
      #1;
      if (rst) begin
         m_valid = 0; m_rd = 0; m_tag = 0; m_val = 0; m_ptr = 0;
      end else if (exp_gnt != 0) begin
         for (int i = 0; i < N; i++)
            if (exp_gnt[i]) begin
               m_valid = 1; m_rd = pl_rd[i]; m_tag = pl_tag[i]; m_val = pl_val[i];
               m_ptr = (i + 1) % N;
            end
      end else begin
         m_valid = 0;
      end
      check("cdb_valid", 64'(cdb_valid), 64'(m_valid));
      check("cdb_rd", 64'(cdb_rd), 64'(m_rd));
      check("cdb_rob_tag", 64'(cdb_rob_tag), 64'(m_tag));
      check("cdb_value", 64'(cdb_value), 64'(m_val));
   endtask

   logic [N-1:0] pend;
   int           waits[N];
   logic         r_rst, r_sq;

   initial begin
      for (int i = 0; i < N; i++) begin
         pl_rd[i] = 5'(i + 10); pl_tag[i] = ROB_TAG_LEN'(i + 20); pl_val[i] = 32'hA000 + i;
      end
      // reset then idle
      drive(1, 0, '0);
      drive(1, 0, '0);
      drive(0, 0, '0);
      drive(0, 0, '0);
      check("idle_valid", 64'(cdb_valid), 64'd0);

      // single request from requester 1
      pl_rd[1] = 5'd5; pl_tag[1] = ROB_TAG_LEN'(3); pl_val[1] = 32'hDEAD;
      drive(0, 0, 4'b0010);
      check("single_ready", 64'(gnt_log[3:0]), 64'h2);
      check("single_value", 64'(cdb_value), 64'hDEAD);
      drive(0, 0, '0);
      check("single_drop", 64'(cdb_valid), 64'd0);

      // all requesting from ptr=0
      drive(1, 0, '0);
      for (int c = 0; c < 5; c++) drive(0, 0, 4'b1111);
      check("rr_order", 64'(gnt_log), 64'h12481);

      // wrap and skip: reach ptr=3, then 0101, then a new request at 3 joins
      drive(0, 0, 4'b0100);
      drive(0, 0, 4'b0101);
      drive(0, 0, 4'b1100);
      drive(0, 0, 4'b1000);
      check("wrap_order", 64'(gnt_log[15:0]), 64'h4148);

      // squash after a grant
      drive(0, 0, 4'b0011);
      drive(0, 1, 4'b0011);
      check("squash_ready", 64'(gnt_log[3:0]), 64'h0);
      drive(0, 0, 4'b0011);
      check("post_squash", 64'(gnt_log[3:0]), 64'h2);

      // reset mid-stream
      drive(1, 0, 4'b1111);
      drive(0, 0, 4'b1111);
      check("post_reset", 64'(gnt_log[3:0]), 64'h1);

      // randomized traffic obeying the hold-until-ready handshake
      pend = '0;
      for (int i = 0; i < N; i++) waits[i] = 0;
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++)
            if (!pend[i] && $urandom_range(1, 0) == 1) begin
               pend[i] = 1'b1;
               pl_rd[i] = 5'($urandom);
               pl_tag[i] = ROB_TAG_LEN'($urandom);
               pl_val[i] = $urandom;
            end
         r_rst = ($urandom_range(63, 0) == 0);
         r_sq = ($urandom_range(15, 0) == 0);
         drive(r_rst, r_sq, pend);
         for (int i = 0; i < N; i++) begin
            if (exp_gnt[i]) begin
               check("fairness", 64'(waits[i] <= N - 1), 64'd1);
               waits[i] = 0;
               pend[i] = 1'b0;
            end else if (pend[i] && exp_gnt != 0) begin
               waits[i]++;
            end
            if (r_rst || r_sq) begin
               pend[i] = 1'b0;
               waits[i] = 0;
            end
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
